// File: rtl/tlc_pkg.sv
// Shared types and helpers for the four-way traffic-light controller.
// Light codes are the raw 2-bit lamp-driver encoding; 2'b11 is never produced.
package tlc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_E = 2'b01,
    DIR_S = 2'b10,
    DIR_W = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_ALL_RED = 2'b10
  } phase_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler: free-running 0..TICK_DIV-1 counter, tick pulses for one cycle at the top count.
// Zero latency (tick decoded from the count register); no backpressure.
module tlc_tick_gen
  import tlc_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = clog2_min1(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_top;

  assign w_top = (r_cnt == CW'(TICK_DIV - 1));
  assign tick  = w_top;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_top) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_cntrl.sv
// Round-robin N/E/S/W light FSM; outputs decode the state register directly (no extra stage), no inputs/backpressure.
// TLC_ALL_RED_EN inserts an ALL_RED clearance phase of ALL_RED_TICKS after every YELLOW.
module traffic_light_cntrl
  import tlc_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int GREEN_TICKS   = 10,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] n_light,
  output logic [1:0] e_light,
  output logic [1:0] s_light,
  output logic [1:0] w_light
);

  localparam int PW = clog2_min1(max3(GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS));

  // State is {direction, phase}
  localparam logic [3:0] S_N_GREEN = {DIR_N, PH_GREEN};

  logic [3:0]    r_state;
  logic [PW-1:0] r_ph_cnt;
  logic          w_tick;
  logic [1:0]    w_dir;
  logic [1:0]    w_dir_nxt;
  logic [1:0]    w_phase;
  logic [PW-1:0] w_last_cnt;
  logic          w_legal;
  logic [3:0]    w_next;
  logic [1:0]    w_col;

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_dir     = r_state[3:2];
  assign w_phase   = r_state[1:0];
  assign w_dir_nxt = w_dir + 2'd1;

  always_comb begin
    w_last_cnt = PW'(GREEN_TICKS - 1);
    w_legal    = 1'b1;
    w_next     = S_N_GREEN;
    case (w_phase)
      PH_GREEN: begin
        w_last_cnt = PW'(GREEN_TICKS - 1);
        w_next     = {w_dir, PH_YELLOW};
      end
      PH_YELLOW: begin
        w_last_cnt = PW'(YELLOW_TICKS - 1);
`ifdef TLC_ALL_RED_EN
        w_next     = {w_dir, PH_ALL_RED};
`else
        w_next     = {w_dir_nxt, PH_GREEN};
`endif
      end
`ifdef TLC_ALL_RED_EN
      PH_ALL_RED: begin
        w_last_cnt = PW'(ALL_RED_TICKS - 1);
        w_next     = {w_dir_nxt, PH_GREEN};
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !w_legal) begin
      r_state  <= S_N_GREEN;
      r_ph_cnt <= '0;
    end else if (w_tick) begin
      if (r_ph_cnt == w_last_cnt) begin
        r_state  <= w_next;
        r_ph_cnt <= '0;
      end else begin
        r_ph_cnt <= r_ph_cnt + 1'b1;
      end
    end
  end

  // Illegal phase encodings decode as all-red until recovery
  always_comb begin
    case (w_phase)
      PH_GREEN:  w_col = GREEN;
      PH_YELLOW: w_col = YELLOW;
      default:   w_col = RED;
    endcase
  end

  assign n_light = (w_dir == DIR_N) ? w_col : RED;
  assign e_light = (w_dir == DIR_E) ? w_col : RED;
  assign s_light = (w_dir == DIR_S) ? w_col : RED;
  assign w_light = (w_dir == DIR_W) ? w_col : RED;

endmodule

// File: tb/tb_traffic_light_cntrl.sv
// Scoreboarded bench: stimulus pushes the hand-derived expected lights per cycle, monitor pops and compares.
// Build with or without TLC_ALL_RED_EN; the expected schedule follows the same macro.
module tb_traffic_light_cntrl;

  localparam int D  = 4;
  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int AR = 1;
`ifdef TLC_ALL_RED_EN
  localparam int PER = (G + Y + AR) * D;  // 24 cycles per approach, 96 per rotation
`else
  localparam int PER = (G + Y) * D;       // 20 cycles per approach, 80 per rotation
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] n_light, e_light, s_light, w_light;

  always #5 clk = ~clk;

  traffic_light_cntrl #(
    .TICK_DIV      (D),
    .GREEN_TICKS   (G),
    .YELLOW_TICKS  (Y),
    .ALL_RED_TICKS (AR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .n_light (n_light),
    .e_light (e_light),
    .s_light (s_light),
    .w_light (w_light)
  );

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         t = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Expected {n,e,s,w} for the cycle that is tt cycles after the last reset edge
  function automatic logic [7:0] expect_at(input int tt);
    int         r, d, off;
    logic [1:0] c;
    logic [7:0] v;
    r   = tt % (4 * PER);
    d   = r / PER;
    off = r % PER;
    if (off < G * D)            c = 2'b10;
    else if (off < (G + Y) * D) c = 2'b01;
    else                        c = 2'b00;
    v = 8'h00;
    v[7 - 2*d -: 2] = c;
    return v;
  endfunction

  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    if (r) t = 0;
    else   t = t + 1;
    exp_q.push_back(expect_at(t));
  endtask

  // Monitor: compare once per cycle, away from the clock edge
  logic [1:0] cur [4];
  logic [1:0] prev[4];
  logic [7:0] exp_v;
  int         nonred;
  logic       bad11;

  initial begin
    for (int i = 0; i < 4; i++) prev[i] = 2'bxx;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk("lights", {n_light, e_light, s_light, w_light}, exp_v);
        cur[0] = n_light; cur[1] = e_light; cur[2] = s_light; cur[3] = w_light;
        nonred = 0;
        bad11  = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (cur[i] != 2'b00) nonred++;
          if (cur[i] == 2'b11) bad11 = 1'b1;
        end
        chk("at_most_one_nonred", 8'(nonred <= 1), 8'h01);
        chk("no_code_11", {7'b0, bad11}, 8'h00);
        for (int i = 0; i < 4; i++) begin
          if (prev[i] === 2'b10 && cur[i] !== 2'b10)
            chk("green_then_yellow", {6'b0, cur[i]}, 8'h01);
          prev[i] = cur[i];
        end
      end
    end
  end

  initial begin
    // Reset held 5 cycles: N green throughout
    repeat (5) step(1'b1);
    // Full rotation plus a few cycles back into N_GREEN
    repeat (4 * PER + 4) step(1'b0);
    // Reset mid N_GREEN restarts the phase
    step(1'b1);
    // Run into E_YELLOW, then a one-cycle reset there
    repeat (PER + G * D + 2) step(1'b0);
    step(1'b1);
    repeat (1000) step(1'b0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
